// File: rtl/instruction_fetch_unit.sv
// Purpose: fetch sequencer between program counter, instruction memory and decode; drives PC increment/redirect.
// Latency: start sampled -> ADDR -> REQ -> HOLD with zero-wait memory; one instruction per 3 cycles at best.
// Backpressure: memory stalls via imem_ack (req held); decoder stalls via ir_ready (ir_* held in HOLD).
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic                   pc_inc,
    output logic                   pc_write,
    output logic [ADDR_WIDTH-1:0]  pc_wdata,
    input  logic                   branch_en,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [INSTR_WIDTH-1:0] ir_data,
    output logic [ADDR_WIDTH-1:0]  ir_pc,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_REQ   = 3'd2,
        S_HOLD  = 3'd3,
        S_REDIR = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Next values of the registered outputs
    logic                   pc_inc_nxt;
    logic                   pc_write_nxt;
    logic [ADDR_WIDTH-1:0]  pc_wdata_nxt;
    logic                   imem_req_nxt;
    logic [ADDR_WIDTH-1:0]  imem_addr_nxt;
    logic                   ir_valid_nxt;
    logic [INSTR_WIDTH-1:0] ir_data_nxt;
    logic [ADDR_WIDTH-1:0]  ir_pc_nxt;
    logic                   busy_nxt;

    // An ack only counts while a request is actually outstanding.
    logic ack_ok;
    logic redirect;
    logic handshake;

    assign ack_ok    = imem_ack && imem_req;
    assign redirect  = branch_en && (state != S_IDLE);
    assign handshake = ir_valid && ir_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect always routes through REDIR or DRAIN so that
    // ADDR never samples pc_in in the same cycle the PC is being loaded.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                state_nxt = redirect ? S_REDIR : S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    state_nxt = ack_ok ? S_REDIR : S_DRAIN;
                end else if (ack_ok) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_nxt = S_REDIR;
                end else if (handshake) begin
                    state_nxt = halt ? S_IDLE : S_ADDR;
                end
            end
            S_REDIR: begin
                state_nxt = redirect ? S_REDIR : S_ADDR;
            end
            S_DRAIN: begin
                // A late redirect landing with the ack still needs a REDIR
                // cycle so the new pc_write completes before ADDR.
                if (redirect) begin
                    state_nxt = ack_ok ? S_REDIR : S_DRAIN;
                end else if (ack_ok) begin
                    state_nxt = S_ADDR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: computes the next value of every registered output
    always_comb begin
        pc_inc_nxt    = 1'b0;
        pc_write_nxt  = 1'b0;
        pc_wdata_nxt  = pc_wdata;
        imem_addr_nxt = imem_addr;
        ir_valid_nxt  = ir_valid;
        ir_data_nxt   = ir_data;
        ir_pc_nxt     = ir_pc;
        imem_req_nxt  = (state_nxt == S_REQ) || (state_nxt == S_DRAIN);
        busy_nxt      = (state_nxt != S_IDLE);

        if (state == S_ADDR) begin
            imem_addr_nxt = pc_in;
        end

        if ((state == S_REQ) && ack_ok) begin
            ir_data_nxt  = imem_rdata;
            ir_pc_nxt    = imem_addr;
            ir_valid_nxt = 1'b1;
            pc_inc_nxt   = 1'b1;
        end

        if ((state == S_HOLD) && handshake) begin
            ir_valid_nxt = 1'b0;
        end

        // Redirect flushes the fetched word and overrides any pending increment.
        if (redirect) begin
            pc_write_nxt = 1'b1;
            pc_wdata_nxt = branch_target;
            pc_inc_nxt   = 1'b0;
            ir_valid_nxt = 1'b0;
            ir_data_nxt  = ir_data;
            ir_pc_nxt    = ir_pc;
        end
    end

    // Output registers; async reset clears everything, abandoning any request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_inc    <= 1'b0;
            pc_write  <= 1'b0;
            pc_wdata  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir_valid  <= 1'b0;
            ir_data   <= '0;
            ir_pc     <= '0;
            busy      <= 1'b0;
        end else begin
            pc_inc    <= pc_inc_nxt;
            pc_write  <= pc_write_nxt;
            pc_wdata  <= pc_wdata_nxt;
            imem_req  <= imem_req_nxt;
            imem_addr <= imem_addr_nxt;
            ir_valid  <= ir_valid_nxt;
            ir_data   <= ir_data_nxt;
            ir_pc     <= ir_pc_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a PC model and a memory model.
// Memory returns addr + 0x1000 after a programmable number of wait cycles.
// Decoder readiness, halt, start and branches are driven step by step.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic [15:0] pc_in;
    logic        pc_inc;
    logic        pc_write;
    logic [15:0] pc_wdata;
    logic        branch_en;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_in(pc_in),
        .pc_inc(pc_inc), .pc_write(pc_write), .pc_wdata(pc_wdata),
        .branch_en(branch_en), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir_data(ir_data), .ir_pc(ir_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // PC model: load from bench, PC write from DUT, else increment
    logic [15:0] pc = 16'h0000;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    int          n_inc = 0;
    int          n_wr = 0;
    assign pc_in = pc;

    always @(posedge clk) begin
        if (pc_load)       pc <= pc_load_val;
        else if (pc_write) pc <= pc_wdata;
        else if (pc_inc)   pc <= pc + 16'd1;
        if (pc_inc)   n_inc <= n_inc + 1;
        if (pc_write) n_wr  <= n_wr + 1;
    end

    // Memory model: ack after ack_delay request cycles
    int ack_delay = 0;
    int wait_cnt = 0;
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = imem_addr + 16'h1000;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    // Watch for any instruction presented from the flushed address 0x0040
    logic seen_0040 = 1'b0;
    always @(posedge clk) begin
        if (ir_valid && ir_pc == 16'h0040) seen_0040 <= 1'b1;
    end

    logic [68:0] outs;
    assign outs = {pc_inc, pc_write, pc_wdata, imem_req, imem_addr,
                   ir_valid, ir_data, ir_pc, busy};

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_load = 1'b1;
        pc_load_val = v;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    // Step negedges until ir_valid, bounded; n is the number of cycles stepped
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir_valid && n < 20);
        chk(tag, {79'd0, ir_valid}, 80'd1);
    endtask

    int n;
    int inc0;
    int wr0;
    int req_cycles;

    initial begin
        rst = 1'b0; start = 1'b0; halt = 1'b0; branch_en = 1'b0;
        branch_target = 16'h0000; ir_ready = 1'b1;

        // Reset state
        set_pc(16'h0024);
        chk("reset_outs", {11'd0, outs}, 80'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---- Test 1: zero-wait streaming from 0x0024 ----
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_addr_busy", {78'd0, busy, imem_req}, 80'b10);
        @(negedge clk);
        chk("t1_req", {63'd0, imem_req, imem_addr}, {63'd0, 1'b1, 16'h0024});
        @(negedge clk);
        chk("t1_first", {46'd0, ir_valid, pc_inc, ir_pc, ir_data},
            {46'd0, 1'b1, 1'b1, 16'h0024, 16'h1024});
        wait_valid("t1_v2", n);
        chk("t1_tput2", 80'(n), 80'd3);
        chk("t1_i2", {48'd0, ir_pc, ir_data}, {48'd0, 16'h0025, 16'h1025});
        wait_valid("t1_v3", n);
        chk("t1_tput3", 80'(n), 80'd3);
        chk("t1_i3", {48'd0, ir_pc, ir_data}, {48'd0, 16'h0026, 16'h1026});
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t1_idle", {78'd0, busy, ir_valid}, 80'd0);
        chk("t1_inc_cnt", 80'(n_inc), 80'd3);
        chk("t1_pc", {64'd0, pc}, {64'd0, 16'h0027});

        // ---- Test 2: 4-cycle memory wait, decoder stalls 3 cycles ----
        ack_delay = 4;
        ir_ready = 1'b0;
        inc0 = n_inc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        req_cycles = 0;
        while (imem_req && req_cycles < 10) begin
            chk("t2_addr_stable", {64'd0, imem_addr}, {64'd0, 16'h0027});
            req_cycles++;
            @(negedge clk);
        end
        chk("t2_req_cycles", 80'(req_cycles), 80'd5);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold", {47'd0, ir_valid, ir_pc, ir_data},
                {47'd0, 1'b1, 16'h0027, 16'h1027});
            if (i > 0) chk("t2_no_dup_inc", {79'd0, pc_inc}, 80'd0);
            @(negedge clk);
        end
        chk("t2_hold_last", {47'd0, ir_valid, ir_pc, ir_data},
            {47'd0, 1'b1, 16'h0027, 16'h1027});
        ir_ready = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t2_idle", {79'd0, busy}, 80'd0);
        chk("t2_inc_delta", 80'(n_inc - inc0), 80'd1);

        // ---- Test 3: redirect in first HOLD cycle of fetch at 0x0030 ----
        ack_delay = 0;
        set_pc(16'h0030);
        wr0 = n_wr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("t3_v", n);
        chk("t3_pc30", {64'd0, ir_pc}, {64'd0, 16'h0030});
        ir_ready = 1'b0;
        branch_en = 1'b1;
        branch_target = 16'h00E5;
        @(negedge clk);
        branch_en = 1'b0;
        chk("t3_redir", {61'd0, pc_write, pc_inc, ir_valid, pc_wdata},
            {61'd0, 1'b1, 1'b0, 1'b0, 16'h00E5});
        ir_ready = 1'b1;
        halt = 1'b1;
        wait_valid("t3_v2", n);
        chk("t3_target", {48'd0, ir_pc, ir_data}, {48'd0, 16'h00E5, 16'h10E5});
        @(negedge clk);
        halt = 1'b0;
        chk("t3_idle", {79'd0, busy}, 80'd0);
        chk("t3_wr_cnt", 80'(n_wr - wr0), 80'd1);
        chk("t3_pc", {64'd0, pc}, {64'd0, 16'h00E6});

        // ---- Test 4: redirect during REQ, ack two cycles later (DRAIN) ----
        ack_delay = 2;
        set_pc(16'h0040);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t4_req", {63'd0, imem_req, imem_addr}, {63'd0, 1'b1, 16'h0040});
        branch_en = 1'b1;
        branch_target = 16'h0100;
        @(negedge clk);
        branch_en = 1'b0;
        chk("t4_drain", {46'd0, pc_write, imem_req, pc_wdata, imem_addr},
            {46'd0, 1'b1, 1'b1, 16'h0100, 16'h0040});
        halt = 1'b1;
        wait_valid("t4_v", n);
        chk("t4_target", {48'd0, ir_pc, ir_data}, {48'd0, 16'h0100, 16'h1100});
        chk("t4_no_0040", {79'd0, seen_0040}, 80'd0);
        @(negedge clk);
        chk("t4_idle", {79'd0, busy}, 80'd0);

        // ---- Test 5: halt during fetch of 0xFFFF, restart wraps to 0x0000 ----
        ack_delay = 0;
        set_pc(16'hFFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("t5_v", n);
        chk("t5_ffff", {48'd0, ir_pc, ir_data}, {48'd0, 16'hFFFF, 16'h0FFF});
        @(negedge clk);
        chk("t5_idle", {79'd0, busy}, 80'd0);
        chk("t5_pc_wrap", {64'd0, pc}, 80'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("t5_v2", n);
        chk("t5_0000", {48'd0, ir_pc, ir_data}, {48'd0, 16'h0000, 16'h1000});
        @(negedge clk);
        halt = 1'b0;
        chk("t5_idle2", {79'd0, busy}, 80'd0);

        // ---- Test 6: asynchronous reset mid-REQ ----
        ack_delay = 50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_in_req", {79'd0, imem_req}, 80'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_clear", {11'd0, outs}, 80'd0);
        @(negedge clk);
        rst = 1'b1;
        inc0 = n_inc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_quiet", {11'd0, outs}, 80'd0);
        end
        chk("t6_no_inc", 80'(n_inc - inc0), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Consumer-side sequencer for the 16-bit program counter. It reads the current PC value, issues a read to instruction memory with a req/ack handshake, and presents the fetched word to the decoder with a valid/ready handshake. It drives the PC's increment and write controls: an increment after each fetch, and a write on a branch redirect. It sits between the program counter, instruction memory and the decode stage of each core.

## Interface
- ADDR_WIDTH, 16, PC / instruction memory address width
- INSTR_WIDTH, 16, instruction word width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin fetching; sampled only in IDLE
- halt  in  1  level; stop after the current instruction handshake
- pc_in  in  ADDR_WIDTH  current program counter value
- pc_inc  out  1  one-cycle pulse: PC increments
- pc_write  out  1  one-cycle pulse: PC loads pc_wdata
- pc_wdata  out  ADDR_WIDTH  redirect target
- branch_en  in  1  one-cycle redirect request
- branch_target  in  ADDR_WIDTH  redirect address
- imem_req  out  1  instruction memory read request
- imem_addr  out  ADDR_WIDTH  read address, stable while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_WIDTH  read data
- ir_valid  out  1  ir_data/ir_pc valid
- ir_ready  in  1  decoder accepts
- ir_data  out  INSTR_WIDTH  fetched instruction
- ir_pc  out  ADDR_WIDTH  address ir_data was fetched from
- busy  out  1  state != IDLE

## Operation
- All outputs are registered. Reset (rst=0) forces state IDLE and every output to 0.
- IDLE: start=1 moves to ADDR.
- ADDR (1 cycle): imem_addr <= pc_in; then REQ.
- REQ: imem_req=1, with imem_addr held, until imem_ack=1. On ack:
  - ir_data <= imem_rdata, ir_pc <= imem_addr, ir_valid <= 1.
  - pc_inc pulses in the next cycle.
  - State moves to HOLD.
- HOLD: ir_valid, ir_data and ir_pc are held until ir_valid&ir_ready. On handshake, ir_valid <= 0, then:
  - halt=1 moves to IDLE;
  - otherwise ADDR.
- Redirect: branch_en=1 sampled in any non-IDLE state does the following:
  - pc_write=1 and pc_wdata=branch_target in the next cycle.
  - ir_valid is cleared (flush).
  - Any pc_inc that would have fired is suppressed; pc_write has priority.
- Redirect next state:
  - From ADDR or HOLD: REDIR.
  - From REQ with no ack that cycle: DRAIN. DRAIN keeps imem_req=1 with the same address until ack, discards the data, then moves to ADDR.
  - From REQ with ack the same cycle: the data is discarded and the state moves to REDIR.
- REDIR (1 cycle, pc_write pulse): then ADDR.
- branch_en in IDLE is ignored.
- A second branch_en during DRAIN takes effect: it produces a new pc_write pulse with the newest target.
- halt=1 while in ADDR, REQ or DRAIN has no effect until the HOLD handshake. A flushed fetch never produces a handshake; after a redirect, halt takes effect at the next HOLD handshake.
- Address arithmetic belongs to the PC; this block never adds. Wrap from 0xFFFF to 0x0000 is transparent.

## Timing
- Minimum fetch, zero-wait memory (ack in the first REQ cycle):
  - start sampled at edge 0;
  - ADDR in cycle 1;
  - REQ in cycle 2;
  - ir_valid=1 and pc_inc=1 in cycle 3.
- Throughput with ir_ready=1 and zero-wait memory: one instruction every 3 cycles (ADDR, REQ, HOLD).
- pc_inc fires in the first HOLD cycle, so the PC updates at the end of that cycle. ADDR is never earlier than the following cycle, so ADDR always latches the updated PC.
- REDIR guarantees the same ordering for pc_write.
- imem_ack is only honoured while imem_req=1. An ack outside REQ/DRAIN is ignored.
- Asynchronous reset mid-REQ drops imem_req immediately; the memory must tolerate an abandoned request.

## Test plan
- Reset, then start=1, with pc_in tracking a PC model starting at 0x0024, zero-wait memory and ir_ready=1:
  - ir_pc sequence is 0x0024, 0x0025, 0x0026;
  - ir_data equals the memory model contents;
  - exactly one pc_inc per instruction.
- Memory ack delayed 4 cycles and ir_ready held low 3 cycles:
  - imem_addr is stable throughout REQ;
  - ir_data and ir_pc are stable while ir_valid=1 and ir_ready=0;
  - no duplicate pc_inc.
- branch_en with target 0x00E5 in the first HOLD cycle of the fetch at 0x0030:
  - pc_inc is suppressed and pc_write pulses with 0x00E5;
  - ir_valid drops;
  - next ir_pc is 0x00E5.
- branch_en with target 0x0100 during REQ, with ack 2 cycles later:
  - DRAIN discards the data;
  - no ir_valid for address 0x0040;
  - next ir_pc is 0x0100.
- halt=1 during the fetch of 0xFFFF:
  - the instruction at 0xFFFF is delivered and the block returns to IDLE with busy=0;
  - a restart fetches from 0x0000 (PC wrap).
- rst=0 asserted mid-REQ:
  - all outputs are 0 immediately, without a clock edge;
  - after release, nothing happens until start=1.
